diff_block_accum: RTL and testbench
===================================

// Module: diff_block_accum
// PURPOSE
//   Downstream consumer of the 4-bit subtractor stage. Takes a stream of differences,
//   reads each one as two's-complement, and sums BLOCK_LEN of them into a signed block sum.
//   Presents each block sum on a valid/ready output port, with an overflow flag.
//   Sits between the subtractor and the result-reporting logic.
// PARAMETERS
//   W          4   width of incoming difference (signed, two's-complement)
//   ACC_W      8   width of accumulator and out_sum (signed); must be >= W
//   BLOCK_LEN  4   samples per block; legal range 1..255
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous abort: drop partial block, return to IDLE
//   in_diff    in   W      difference sample from subtractor
//   in_valid   in   1      in_diff valid
//   in_ready   out  1      stage can accept a sample this cycle
//   out_sum    out  ACC_W  completed block sum (signed)
//   out_ovf    out  1      signed overflow occurred within this block
//   out_valid  out  1      out_sum/out_ovf valid
//   out_ready  in   1      consumer accepts result
// BEHAVIOUR
//   - Reset (rst_n low, async): state=IDLE, acc=0, count=0, out_sum=0, out_ovf=0,
//     out_valid=0. in_ready=1 once rst_n deasserts.
//   - Accept: a sample is accepted when in_valid & in_ready are both high at a rising edge.
//     in_diff is sign-extended W->ACC_W and added to acc.
//   - FSM:
//     IDLE : in_ready=1. On accept: acc=sext(in_diff), count=1.
//            If BLOCK_LEN==1, go to HOLD; otherwise go to ACCUM.
//     ACCUM: in_ready=1. On accept: acc+=sext, count++.
//            When count reaches BLOCK_LEN, go to HOLD.
//     HOLD : in_ready=0. out_valid=1, out_sum=final acc, out_ovf=sticky flag.
//            On out_ready: out_valid=0 next cycle and state=IDLE.
//            No sample is accepted in the same cycle as this handoff.
//   - Latency: out_valid rises the cycle after the BLOCK_LEN-th accept.
//   - out_sum and out_ovf hold stable while out_valid=1 and out_ready=0.
//   - Overflow: a signed add overflows when the operand signs match and the result sign
//     differs. Any such add sets the sticky ovf flag for the block. The flag clears on a
//     new block start (IDLE accept).
//   - in_valid low in ACCUM: hold state, acc and count unchanged; no timeout.
//   - clear: wins over every other event in the same cycle. Next state=IDLE, acc=0,
//     count=0, out_valid=0. A pending HOLD result is discarded.
//   - rst_n asserted mid-block or in HOLD: all state returns to reset values
//     immediately (async).
//   - in_diff is ignored when no accept occurs. X on in_diff with in_valid=0 must not
//     propagate.
// CONFIGURATION
//   DIFF_ACC_SAT_EN defined:
//     On overflow, acc clamps to the signed max (+2^(ACC_W-1)-1) or min (-2^(ACC_W-1)),
//     chosen by the operand sign. Later adds continue from the clamped value.
//     out_ovf is still set.
//   DIFF_ACC_SAT_EN undefined:
//     acc wraps modulo 2^ACC_W. out_ovf is set identically.
// TESTING
//   1. Defaults. Diffs 3,4,3,4 with in_valid held high ->
//      out_valid the cycle after the 4th accept; out_sum=14, out_ovf=0.
//   2. Negative diffs 4'hD(-3), 4'h1, 4'hE(-2), 4'h0 -> out_sum=8'hFC (-4), out_ovf=0.
//   3. Backpressure. Hold out_ready=0 for 5 cycles in HOLD ->
//      out_sum stable, in_ready=0 throughout; state=IDLE the cycle after out_ready=1.
//   4. ACC_W=6, BLOCK_LEN=15, fifteen samples of 4'd7:
//      DIFF_ACC_SAT_EN -> out_sum=6'h1F, out_ovf=1.
//      Without the macro -> out_sum=6'h29, out_ovf=1.
//   5. Abort paths:
//      - clear after 2 of 4 samples, then 4 samples of 1 -> out_sum=4.
//      - rst_n pulsed low in HOLD -> out_valid=0 immediately.
//   6. Gaps: in_valid toggled 1/0 each cycle with diffs 1,1,1,1 ->
//      out_sum=4; no extra sample counted during in_valid=0 cycles.

Source files
------------

// File: rtl/diff_block_accum_if.sv
// Valid/ready bus between the subtractor, the block accumulator and the result reporter.
interface diff_block_accum_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 8
);
  logic [W-1:0]     in_diff;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_diff, in_valid, out_ready,
    input  in_ready, out_sum, out_ovf, out_valid
  );

  modport slave (
    input  in_diff, in_valid, out_ready,
    output in_ready, out_sum, out_ovf, out_valid
  );
endinterface

// File: rtl/diff_block_accum.sv
// Sums BLOCK_LEN signed differences into a block sum with a sticky overflow flag.
// Optional DIFF_ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module diff_block_accum #(
  parameter int unsigned W         = 4,
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  diff_block_accum_if.slave   bus
);
  localparam int unsigned CNT_W = 8;
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    in_ready_q;
  logic                    out_valid_q;

  logic                    accept_c;
  logic [ACC_W-1:0]        sext_c;
  logic [ACC_W-1:0]        base_c;
  logic [ACC_W-1:0]        sum_c;
  logic [ACC_W-1:0]        add_c;
  logic                    add_ovf_c;

  assign accept_c = bus.in_valid & in_ready_q;

  // Gate the sample so an undriven in_diff never reaches the adder
  assign sext_c = accept_c ? ACC_W'(signed'(bus.in_diff)) : '0;
  assign base_c = (state_q == IDLE) ? '0 : acc_q;
  assign sum_c  = base_c + sext_c;
  assign add_ovf_c = (base_c[ACC_W-1] == sext_c[ACC_W-1]) &&
                     (sum_c[ACC_W-1] != base_c[ACC_W-1]);

`ifdef DIFF_ACC_SAT_EN
  assign add_c = add_ovf_c ? (sext_c[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum_c;
`else
  assign add_c = sum_c;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            acc_d   = add_c;
            cnt_d   = CNT_W'(1);
            ovf_d   = add_ovf_c;
            state_d = (BLOCK_LEN == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            acc_d = add_c;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf_c;
            if (cnt_d == CNT_W'(BLOCK_LEN)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
    end
  end

  // acc is frozen in HOLD, so it doubles as the stable result register
  assign bus.in_ready  = in_ready_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_diff_block_accum.sv
// Bench for diff_block_accum: vector table, corner sequences and a randomized model check.
module tb_diff_block_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear0 = 1'b0;
  logic clear1 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  diff_block_accum_if #(.W(4), .ACC_W(8)) if0 ();
  diff_block_accum_if #(.W(4), .ACC_W(6)) if1 ();

  diff_block_accum #(.W(4), .ACC_W(8), .BLOCK_LEN(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .bus(if0));
  diff_block_accum #(.W(4), .ACC_W(6), .BLOCK_LEN(15)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(if1));

  typedef struct {
    logic [15:0] diffs;
    bit          gaps;
    logic [7:0]  exp_sum;
    bit          exp_ovf;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: mathematical sum with range check; wrap or clamp when out of range
  function automatic int model_add(input int a, input int d, input int aw, output bit o);
    int t, mx, mn;
    t  = a + d;
    mx = (1 << (aw - 1)) - 1;
    mn = -(1 << (aw - 1));
    o  = (t > mx) || (t < mn);
    if (!o) return t;
`ifdef DIFF_ACC_SAT_EN
    return (t > mx) ? mx : mn;
`else
    return (t > mx) ? t - (1 << aw) : t + (1 << aw);
`endif
  endfunction

  task automatic send4(input logic [15:0] ds, input bit gaps, input string tag);
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1'b1;
      if0.in_diff  = ds[4*i +: 4];
      step();
      if0.in_valid = 1'b0;
      if0.in_diff  = 4'hA;
      check({tag, "_ovld"}, 32'(if0.out_valid), 32'(i == 3));
      if (gaps && i < 3) step();
    end
  endtask

  task automatic finish_block(input logic [7:0] es, input bit eo, input string tag);
    check({tag, "_sum"}, 32'(if0.out_sum), 32'(es));
    check({tag, "_ovf"}, 32'(if0.out_ovf), 32'(eo));
    check({tag, "_irdy_hold"}, 32'(if0.in_ready), 32'(0));
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
    check({tag, "_ovld_drop"}, 32'(if0.out_valid), 32'(0));
    check({tag, "_irdy_idle"}, 32'(if0.in_ready), 32'(1));
  endtask

  initial begin
    bit   m_hold, m_ovf, o;
    int   m_cnt, m_acc, d;
    logic [7:0] exp8;

    vecs[0] = '{16'h4343, 1'b0, 8'd14,  1'b0, "pos"};
    vecs[1] = '{16'h0E1D, 1'b0, 8'hFC,  1'b0, "neg"};
    vecs[2] = '{16'h7777, 1'b0, 8'h1C,  1'b0, "max"};
    vecs[3] = '{16'h8888, 1'b0, 8'hE0,  1'b0, "min"};
    vecs[4] = '{16'hFFFF, 1'b0, 8'hFC,  1'b0, "m1"};
    vecs[5] = '{16'h1111, 1'b1, 8'd4,   1'b0, "gaps"};

    if0.in_valid = 1'b0; if0.in_diff = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_diff = '0; if1.out_ready = 1'b0;

    #2;
    check("rst_ovld", 32'(if0.out_valid), 32'(0));
    check("rst_sum",  32'(if0.out_sum),   32'(0));
    check("rst_ovf",  32'(if0.out_ovf),   32'(0));
    #10 rst_n = 1'b1;
    step();
    check("rst_irdy", 32'(if0.in_ready), 32'(1));

    foreach (vecs[k]) begin
      send4(vecs[k].diffs, vecs[k].gaps, vecs[k].name);
      finish_block(vecs[k].exp_sum, vecs[k].exp_ovf, vecs[k].name);
    end

    // Backpressure: result stable and nothing accepted while held or during handoff
    send4(16'h4343, 1'b0, "bp");
    if0.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if0.in_diff = 4'($urandom);
      step();
      check("bp_sum",  32'(if0.out_sum),   32'(14));
      check("bp_irdy", 32'(if0.in_ready),  32'(0));
      check("bp_ovld", 32'(if0.out_valid), 32'(1));
    end
    if0.in_diff = 4'd7;
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
    if0.in_valid = 1'b0;
    check("bp_ovld_drop", 32'(if0.out_valid), 32'(0));
    check("bp_irdy_idle", 32'(if0.in_ready),  32'(1));
    send4(16'h1111, 1'b0, "bp_next");
    finish_block(8'd4, 1'b0, "bp_next");

    // Clear after two samples drops the partial block
    if0.in_valid = 1'b1; if0.in_diff = 4'd5;
    step(); step();
    if0.in_valid = 1'b0;
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    check("clr_ovld", 32'(if0.out_valid), 32'(0));
    send4(16'h1111, 1'b0, "clr");
    finish_block(8'd4, 1'b0, "clr");

    // Clear in HOLD discards the result
    send4(16'h4343, 1'b0, "clrh");
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    check("clrh_ovld", 32'(if0.out_valid), 32'(0));
    check("clrh_irdy", 32'(if0.in_ready),  32'(1));

    // Async reset in HOLD takes effect without a clock edge
    send4(16'h4343, 1'b0, "arst");
    rst_n = 1'b0;
    #1;
    check("arst_ovld", 32'(if0.out_valid), 32'(0));
    check("arst_sum",  32'(if0.out_sum),   32'(0));
    #2 rst_n = 1'b1;
    step();
    check("arst_irdy", 32'(if0.in_ready), 32'(1));

    // Narrow accumulator, long block: overflow path
    for (int i = 0; i < 15; i++) begin
      if1.in_valid = 1'b1;
      if1.in_diff  = 4'd7;
      step();
      if1.in_valid = 1'b0;
      check("w6_ovld", 32'(if1.out_valid), 32'(i == 14));
    end
`ifdef DIFF_ACC_SAT_EN
    check("w6_sum", 32'(if1.out_sum), 32'(6'h1F));
`else
    check("w6_sum", 32'(if1.out_sum), 32'(6'h29));
`endif
    check("w6_ovf", 32'(if1.out_ovf), 32'(1));
    if1.out_ready = 1'b1;
    step();
    if1.out_ready = 1'b0;
    check("w6_ovld_drop", 32'(if1.out_valid), 32'(0));

    // Randomized traffic against the reference model
    clear0 = 1'b1;
    step();
    clear0 = 1'b0;
    m_hold = 1'b0; m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      check("rnd_irdy", 32'(if0.in_ready),  32'(!m_hold));
      check("rnd_ovld", 32'(if0.out_valid), 32'(m_hold));
      if (m_hold) begin
        exp8 = 8'(m_acc);
        check("rnd_sum", 32'(if0.out_sum), 32'(exp8));
        check("rnd_ovf", 32'(if0.out_ovf), 32'(m_ovf));
      end
      if0.in_valid  = ($urandom_range(0, 3) != 0);
      if0.in_diff   = 4'($urandom);
      if0.out_ready = ($urandom_range(0, 2) == 0);
      clear0        = ($urandom_range(0, 59) == 0);
      if (clear0) begin
        m_hold = 1'b0; m_cnt = 0;
      end else if (m_hold) begin
        if (if0.out_ready) m_hold = 1'b0;
      end else if (if0.in_valid) begin
        d = int'(if0.in_diff);
        if (d > 7) d -= 16;
        m_acc = model_add((m_cnt == 0) ? 0 : m_acc, d, 8, o);
        m_ovf = (m_cnt == 0) ? o : (m_ovf | o);
        m_cnt++;
        if (m_cnt == 4) begin
          m_hold = 1'b1;
          m_cnt  = 0;
        end
      end
      step();
    end
    clear0 = 1'b0;
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
